// File: rtl/btb_set_assoc.sv
// -----------------------------------------------------------------------------
// btb_set_assoc -- parametrised set-associative branch target buffer.
//
// Looked up combinationally from the IF stage and trained from the EX stage
// when a branch or jump resolves. Each entry holds valid, tag, target and a
// 2-bit saturating direction counter. Each set also holds a round-robin victim
// pointer. A taken miss fills the lowest-numbered invalid way. If every way is
// valid, it replaces the way named by the victim pointer and advances it.
//
// Parameters:
//   INDEX_BITS  log2 of the set count
//   WAYS        associativity (1, 2 or 4)
//   PC_WIDTH    PC / target width; tag = pc[PC_WIDTH-1:INDEX_BITS+2]
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   lookup_valid      fetch lookup qualifier (only feeds the statistics)
//   lookup_pc         fetch PC
//   hit               valid tag match in the indexed set
//   predict_taken     hit and counter MSB of the matching way
//   predicted_target  target of the matching way, 0 on a miss
//   upd_valid/pc/taken/target  resolved control-flow instruction
//   flush             invalidate every entry
//
// Optional build macro BTB_STATS_EN adds stat_hits / stat_misses. These are
// saturating 32-bit counts of qualified lookups. Only rst clears them.
// -----------------------------------------------------------------------------
module btb_set_assoc #(
    parameter int INDEX_BITS = 3,
    parameter int WAYS       = 2,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                hit,
    output logic                predict_taken,
    output logic [PC_WIDTH-1:0] predicted_target,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                flush
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
`endif
);

    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = PC_WIDTH - 2 - INDEX_BITS;
    // A 1-bit pointer is kept for WAYS=1. It never leaves 0.
    localparam int VP_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [PC_WIDTH-1:0] target;
        logic [1:0]          ctr;
    } entry_t;

    entry_t             set_q [SETS][WAYS];
    logic [VP_BITS-1:0] vp_q  [SETS];

    logic [INDEX_BITS-1:0] upd_idx, lk_idx;
    logic [TAG_BITS-1:0]   upd_tag, lk_tag;

    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign lk_idx  = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag  = lookup_pc[PC_WIDTH-1:INDEX_BITS+2];

    // ---------------------------------------------------------------------
    // Post-update contents of the set addressed by upd_pc. The same values
    // are written at the edge and forwarded to a same-index lookup. This
    // makes the bypass identical to a lookup on the following cycle.
    // ---------------------------------------------------------------------
    entry_t             upd_set_d [WAYS];
    logic [VP_BITS-1:0] upd_vp_d;
    logic               upd_match, inv_found;
    logic [VP_BITS-1:0] match_way, inv_way, alloc_way;

    always_comb begin
        upd_match = 1'b0;
        match_way = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            upd_set_d[w] = set_q[upd_idx][w];
        end
        upd_vp_d = vp_q[upd_idx];

        for (int w = 0; w < WAYS; w++) begin
            if (!upd_match && upd_set_d[w].valid && upd_set_d[w].tag == upd_tag) begin
                upd_match = 1'b1;
                match_way = VP_BITS'(w);
            end
        end
        // Scan downwards so the lowest invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!upd_set_d[w].valid) begin
                inv_found = 1'b1;
                inv_way   = VP_BITS'(w);
            end
        end
        alloc_way = inv_found ? inv_way : vp_q[upd_idx];

        if (upd_match) begin
            if (upd_taken) begin
                if (upd_set_d[match_way].ctr != 2'b11)
                    upd_set_d[match_way].ctr = upd_set_d[match_way].ctr + 2'd1;
                upd_set_d[match_way].target = upd_target;
            end else if (upd_set_d[match_way].ctr != 2'b00) begin
                upd_set_d[match_way].ctr = upd_set_d[match_way].ctr - 2'd1;
            end
        end else if (upd_taken) begin
            upd_set_d[alloc_way] = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: 2'b10};
            if (!inv_found && WAYS > 1)
                upd_vp_d = vp_q[upd_idx] + 1'b1;
        end
    end

    // rst and flush both outrank the update and suppress the bypass.
    logic bypass;
    assign bypass = upd_valid && !rst && !flush && (upd_idx == lk_idx);

    // ---------------------------------------------------------------------
    // Lookup
    // ---------------------------------------------------------------------
    entry_t          lk_set   [WAYS];
    logic [WAYS-1:0] lk_match;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            lk_set[w] = bypass ? upd_set_d[w] : set_q[lk_idx][w];
        end
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
        assign lk_match[gi] = lk_set[gi].valid && (lk_set[gi].tag == lk_tag);
    end

    // Allocation never creates duplicate tags, so at most one way matches.
    always_comb begin
        hit              = 1'b0;
        predict_taken    = 1'b0;
        predicted_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_match[w]) begin
                hit              = 1'b1;
                predict_taken    = lk_set[w].ctr[1];
                predicted_target = lk_set[w].target;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage. Only valid bits and victim pointers are reset. A cleared
    // valid bit masks tag/target/ctr on every read path.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    set_q[s][w].valid <= 1'b0;
                end
                vp_q[s] <= '0;
            end
        end else if (upd_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                set_q[upd_idx][w] <= upd_set_d[w];
            end
            vp_q[upd_idx] <= upd_vp_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (lookup_valid) begin
            if (hit && stat_hits_q != 32'hFFFF_FFFF)
                stat_hits_q <= stat_hits_q + 32'd1;
            else if (!hit && stat_misses_q != 32'hFFFF_FFFF)
                stat_misses_q <= stat_misses_q + 32'd1;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    logic unused_lookup_valid;
    assign unused_lookup_valid = lookup_valid;
`endif

    // Byte-offset bits play no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

endmodule

// File: doc/btb_set_assoc.md
Name: btb_set_assoc

Overview:
- Parametrised set-associative branch target buffer. Successor to the 8-set direct storage file.
- Adds N-way associativity, tag compare, per-entry 2-bit direction counters, invalid-first/round-robin replacement, flush, and write-first lookup bypass.
- Sits in the IF stage for lookup. Updated from the EX stage on branch/jump resolution.

Parameters:
- INDEX_BITS, 3, log2 of set count (SETS = 2^INDEX_BITS).
- WAYS, 2, associativity; legal values 1, 2, 4.
- PC_WIDTH, 32, PC and target width. Tag width TAG_BITS = PC_WIDTH-2-INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- lookup_valid  in  1  fetch lookup this cycle (qualifies stats only).
- lookup_pc  in  PC_WIDTH  fetch PC.
- hit  out  1  tag match on a valid way in the indexed set.
- predict_taken  out  1  hit AND counter[1] of the matching way.
- predicted_target  out  PC_WIDTH  target of the matching way; 0 when hit=0.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  PC_WIDTH  actual target.
- flush  in  1  invalidate all entries.

Behaviour:
- Field split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2]
  - pc[1:0] ignored.
- Entry contents: valid, tag, target, ctr[1:0]. Each set also holds a victim pointer vp of log2(WAYS) bits (0 bits when WAYS=1).
- Lookup: combinational, zero latency.
  - At most one way may match; the allocation rules guarantee this.
  - hit=0 forces predict_taken=0 and predicted_target=0.
- Update: takes effect at the clk edge when upd_valid=1.
  - Update hit (tag match in the set): ctr saturating ±1 (inc if taken, dec if not; 3 and 0 saturate). Target overwritten only if upd_taken=1. vp unchanged.
  - Update miss, upd_taken=1: allocate the lowest-numbered invalid way. If no way is invalid, use way vp and then vp←vp+1 mod WAYS. New entry: valid=1, tag, target, ctr=2'b10.
  - Update miss, upd_taken=0: no state change.
- Write-first bypass: if upd_valid=1 and the update index equals the lookup index in the same cycle, outputs reflect post-update set contents.
  - Covers a new allocation, a counter change and an evicted way.
  - Exactly matches what a lookup would return on the next cycle.
- rst and flush: all valid←0 and all vp←0 on the edge. Tag, target and ctr are don't-care.
  - Priority: rst > flush > update. An update in a flush cycle is discarded.
  - Bypass is disabled while rst or flush is asserted: outputs show pre-edge state.
- Reset values: after the reset edge with no update, hit=0, predict_taken=0, predicted_target=0. Any mid-operation reset behaves identically.
- WAYS=1: direct-mapped; a taken miss always replaces way 0.
- No X on outputs after the first reset. Unused entries are never read as a hit.

Optional Feature:
- Macro BTB_STATS_EN.
- Defined:
  - Adds outputs stat_hits and stat_misses, 32 bits each.
  - Counted on cycles with lookup_valid=1 according to hit.
  - Saturate at 32'hFFFF_FFFF. Cleared by rst only, not by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold lookup and allocate:
  - After rst, lookup_pc=0x0000_0040 -> hit=0, predicted_target=0.
  - Then upd_valid=1, upd_pc=0x40, upd_taken=1, upd_target=0x100 -> next cycle lookup 0x40 gives hit=1, predict_taken=1, target=0x100.
- Counter saturation: three not-taken updates on 0x40 -> predict_taken goes 0 after the first (ctr 10→01), stays hit=1 with ctr=0. Two taken updates -> predict_taken=1 again.
- Replacement, INDEX_BITS=3, WAYS=2:
  - Taken updates to 0x40, 0x60, 0x80 (all index 0) -> 0x40 evicted (vp=0).
  - Lookup 0x60 and 0x80 hit; 0x40 misses.
  - A fourth, 0xA0, evicts 0x60.
- Same-cycle bypass: lookup_pc=0x200 while an update allocates 0x200→0x300 -> hit=1, predicted_target=0x300 in that cycle.
- Flush priority: flush=1 with a taken update to 0x44 -> next cycle all lookups miss, including 0x44.
- Stats (BTB_STATS_EN): 5 lookup_valid cycles (2 hits, 3 misses), then rst -> counters read 2/3, then 0/0 after rst.
